// File: rtl/seg7_scan_driver.sv
// Multiplexed BCD seven-segment scan driver: shadow-latched digits, refresh scan, blink, polarity.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 250,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);
  localparam bit INV = (ACTIVE_LOW != 0);

  logic [NUM_DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [RW-1:0]              rcnt_q, rcnt_d;
  logic [BW-1:0]              bcnt_q, bcnt_d;
  logic                       phase_q, phase_d;
  logic                       wrap_q, wrap_d;
  logic                       fd_q;
  logic [6:0]                 seg_q, seg_d;
  logic [NUM_DIGITS-1:0]      dig_q, dig_d;

  logic                       tick;
  logic [3:0]                 cur_code;
  logic                       cur_blank;
  logic                       lit;
  logic [NUM_DIGITS-1:0]      blank;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    glyph = 7'b1111110;
      4'd1:    glyph = 7'b0110000;
      4'd2:    glyph = 7'b1101101;
      4'd3:    glyph = 7'b1111001;
      4'd4:    glyph = 7'b0110011;
      4'd5:    glyph = 7'b1011011;
      4'd6:    glyph = 7'b1011111;
      4'd7:    glyph = 7'b1110000;
      4'd8:    glyph = 7'b1111111;
      4'd9:    glyph = 7'b1110011;
      default: glyph = 7'b0000001;
    endcase
  endfunction

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic allz;
  // A digit is blank when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    blank = '0;
    allz  = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      allz     = allz && (shadow_q[k] == 4'd0);
      blank[k] = allz;
    end
  end
`else
  assign blank = '0;
`endif

  // Scan and blink next-state
  always_comb begin
    tick     = (rcnt_q == RCNT_LAST);
    rcnt_d   = tick ? '0 : rcnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    wrap_d   = tick && (idx_q == IDX_LAST);
    shadow_d = load ? digits_in : shadow_q;
    phase_d  = phase_q;
    bcnt_d   = bcnt_q;
    if (!blink_en) begin
      phase_d = 1'b1;
      bcnt_d  = '0;
    end else if (tick) begin
      if (bcnt_q == BCNT_LAST) begin
        phase_d = ~phase_q;
        bcnt_d  = '0;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Output decode of the current index and shadow contents
  always_comb begin
    cur_code  = 4'd0;
    cur_blank = 1'b0;
    dig_d     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_code  = shadow_q[k];
        cur_blank = blank[k];
        dig_d[k]  = 1'b1;
      end
    end
    lit   = phase_q || !blink_en;
    seg_d = (lit && !cur_blank) ? glyph(cur_code) : 7'b0000000;
    seg_d = seg_d ^ {7{INV}};
    dig_d = dig_d ^ {NUM_DIGITS{INV}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      idx_q    <= '0;
      rcnt_q   <= '0;
      bcnt_q   <= '0;
      phase_q  <= 1'b1;
      wrap_q   <= 1'b0;
      fd_q     <= 1'b0;
      seg_q    <= {7{INV}};
      dig_q    <= {NUM_DIGITS{INV}};
    end else begin
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      rcnt_q   <= rcnt_d;
      bcnt_q   <= bcnt_d;
      phase_q  <= phase_d;
      wrap_q   <= wrap_d;
      // Delayed one stage so the pulse lines up with dig_sel showing digit 0
      fd_q     <= wrap_q;
      seg_q    <= seg_d;
      dig_q    <= dig_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: arithmetic reference model, two polarity instances.
module tb_seg7_scan_driver;
  localparam int N = 3;
  localparam int R = 4;
  localparam int B = 2;

  typedef struct packed {
    logic [6:0]   seg;
    logic [N-1:0] dig;
    logic         fd;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [4*N-1:0]  digits_in = '0;
  logic            load = 1'b0;
  logic            blink_en = 1'b0;
  logic [6:0]      seg_h, seg_l;
  logic [N-1:0]    dig_h, dig_l;
  logic            fd_h, fd_l;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  // model state
  int t = 0;
  int nb = 0;
  int m_idx = 0;
  int shadow[N];
  logic [6:0] glyphs [16];

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blink_en(blink_en),
    .seg(seg_h), .dig_sel(dig_h), .frame_done(fd_h));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(B), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .blink_en(blink_en),
    .seg(seg_l), .dig_sel(dig_l), .frame_done(fd_l));

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%b want=%b", name, t, got, want);
    end
  endtask

  // Drive one edge worth of inputs and push what the pins must show after that edge.
  task automatic cycle(input bit r, input bit ld, input logic [4*N-1:0] din, input bit be);
    exp_t e;
    int d;
    bit lit, lz;
    @(negedge clk);
    rst = r; load = ld; digits_in = din; blink_en = be;
    if (r) begin
      e = '0;
      t = 0; nb = 0; m_idx = 0;
      for (int k = 0; k < N; k++) shadow[k] = 0;
    end else begin
      t++;
      m_idx = ((t - 1) / R) % N;
      e.dig = N'(1) << m_idx;
      e.fd  = (t > 1) && ((t - 1) % (R * N) == 0);
      lit   = !be || ((nb / B) % 2 == 0);
      d     = shadow[m_idx];
      e.seg = glyphs[d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lz = (m_idx > 0);
      for (int k = m_idx; k < N; k++) if (shadow[k] != 0) lz = 0;
      if (lz) e.seg = 7'b0;
`else
      lz = 0;
`endif
      if (!lit) e.seg = 7'b0;
      if (be) begin
        if (t % R == 0) nb++;
      end else nb = 0;
      if (ld) for (int k = 0; k < N; k++) shadow[k] = int'(din[4*k +: 4]);
    end
    q.push_back(e);
  endtask

  // Monitor: pins are presented every cycle, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("seg",        {1'b0, seg_h}, {1'b0, e.seg});
        chk("dig_sel",    {5'b0, dig_h}, {5'b0, e.dig});
        chk("frame_done", {7'b0, fd_h},  {7'b0, e.fd});
        chk("seg_al",     {1'b0, seg_l}, {1'b0, ~e.seg});
        chk("dig_sel_al", {5'b0, dig_l}, {5'b0, ~e.dig});
        chk("fd_al",      {7'b0, fd_l},  {7'b0, e.fd});
      end
    end
  end

  initial begin
    bit be;
    int guard;
    glyphs[0] = 7'b1111110; glyphs[1] = 7'b0110000; glyphs[2] = 7'b1101101;
    glyphs[3] = 7'b1111001; glyphs[4] = 7'b0110011; glyphs[5] = 7'b1011011;
    glyphs[6] = 7'b1011111; glyphs[7] = 7'b1110000; glyphs[8] = 7'b1111111;
    glyphs[9] = 7'b1110011;
    for (int k = 10; k < 16; k++) glyphs[k] = 7'b0000001;

    cycle(1, 0, '0, 0);
    cycle(1, 1, 12'h999, 1);
    // release: explicit scan-position checks at cycles 1, 5, 9, 13
    for (int c = 1; c <= 16; c++) begin
      cycle(0, 0, '0, 0);
      @(posedge clk); #2;
      if (c == 1)  chk("rel_dig_c1",  {5'b0, dig_h}, 8'b001);
      if (c == 5)  chk("rel_dig_c5",  {5'b0, dig_h}, 8'b010);
      if (c == 9)  chk("rel_dig_c9",  {5'b0, dig_h}, 8'b100);
      if (c == 13) chk("rel_dig_c13", {5'b0, dig_h}, 8'b001);
      if (c == 12 || c == 13 || c == 14)
        chk("rel_fd", {7'b0, fd_h}, {7'b0, (c == 13)});
    end

    cycle(0, 1, 12'h259, 0);
    repeat (14) cycle(0, 0, 12'hfff, 0);
    cycle(0, 1, 12'h0af, 0);
    repeat (14) cycle(0, 0, '0, 0);
    cycle(0, 1, 12'h123, 1);
    repeat (40) cycle(0, 0, '0, 1);
    repeat (6) cycle(0, 0, '0, 0);
    cycle(0, 1, 12'h456, 0);
    guard = 0;
    do begin cycle(0, 0, '0, 0); guard++; end while (m_idx != 2 && guard < 20);
    cycle(1, 0, '0, 0);
    repeat (14) cycle(0, 0, '0, 0);
    cycle(0, 1, 12'h008, 0);
    repeat (6) cycle(0, 0, '0, 0);
    cycle(0, 1, 12'h000, 0);
    repeat (14) cycle(0, 0, '0, 0);

    be = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(39) == 0) be = !be;
      cycle($urandom_range(199) == 0, $urandom_range(5) == 0,
            (4*N)'($urandom), be);
    end

    @(posedge clk); #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised successor of the three-digit combinational BCD-to-seven-segment decoder used by the microwave timer display.
- Latches NUM_DIGITS BCD digits into a shadow register and time-multiplexes them onto one shared segment bus, with a one-hot digit select.
- Adds a refresh scan counter, a blink mode, a defined glyph for invalid codes, and selectable output polarity.
- Sits between the countdown timer (minutes / seconds tens / seconds ones) and the board display pins.

Parameters:
- NUM_DIGITS, 3: digits scanned; legal range 1..8.
- REFRESH_DIV, 1000: clock cycles each digit is driven; legal range >= 2.
- BLINK_DIV, 250: scan ticks per blink half-period; legal range >= 1.
- ACTIVE_LOW, 0: 1 inverts seg and dig_sel at the output register.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- digits_in  input  4*NUM_DIGITS  BCD digits; [3:0] is digit 0 (least significant, seconds ones)
- load  input  1  when high, shadow register <= digits_in at this edge
- blink_en  input  1  enables display blinking (e.g. while paused or on "done")
- seg  output  7  segments, seg[6]=a ... seg[0]=g; 1 = lit when ACTIVE_LOW=0
- dig_sel  output  NUM_DIGITS  one-hot digit enable; 1 = enabled when ACTIVE_LOW=0
- frame_done  output  1  one-cycle pulse when the scan wraps back to digit 0

Behaviour:
- Reset (rst=1 at an edge) clears the following:
  - shadow register = 0; scan index = 0; refresh counter = 0; blink counter = 0; blink phase = on; frame_done = 0.
  - seg and dig_sel are all inactive: 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.
  - Reset overrides load and any scan or blink activity in the same cycle. Reset mid-frame restarts the scan at digit 0.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1. The terminal count produces an internal scan tick and the counter wraps to 0.
  - On a tick, scan index advances; NUM_DIGITS-1 wraps to 0.
- frame_done is registered and goes high for exactly one cycle, on the cycle the index becomes 0 after wrapping. It is never asserted by reset.
- Outputs are registered and decode the current index every cycle:
  - dig_sel = onehot(index).
  - seg = glyph(shadow[index]).
  - Latency is 1 cycle from an index or shadow change to the pins. The first cycle after reset release drives digit 0 (dig_sel=001 for 3 digits).
- load:
  - The shadow register updates at the load edge; the new value reaches seg one cycle later.
  - load together with a scan tick in the same cycle: both take effect.
  - digits_in is ignored while load=0.
- Glyphs:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011.
  - Codes 10..15 display a dash, 0000001. Output is never X.
- Blink:
  - While blink_en=1, the blink counter counts scan ticks. Every BLINK_DIV ticks the blink phase toggles and the counter clears.
  - While the phase is off, seg is forced inactive; dig_sel keeps scanning and frame_done is unaffected.
  - blink_en=0 forces phase on and clears the blink counter in the same cycle. Re-enabling therefore always starts with a full on half-period.
- Polarity: ACTIVE_LOW is applied as a final inversion of seg and dig_sel only. frame_done is always active-high.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k>0) is blanked (seg inactive) when it holds 0 and every higher digit also holds 0. Digit 0 is never blanked, so 0:07 on 3 digits displays as "  7". Blanking is evaluated on the shadow register.
- Undefined: all digits are displayed, including leading zeros.

Test Plan:
- Configuration for all scenarios unless stated: NUM_DIGITS=3, REFRESH_DIV=4, BLINK_DIV=2, ACTIVE_LOW=0.
- Reset, then release -> seg=0000000 and dig_sel=000 during reset. First cycle after release: dig_sel=001. dig_sel is 010 at cycle 5, 100 at cycle 9, and 001 again at cycle 13 with frame_done high for exactly that cycle.
- Load digits_in=0x259 -> while dig_sel=001, seg=1110011 (9); while 010, seg=1011011 (5); while 100, seg=1101101 (2).
- Load 0x0AF -> digits 0 and 1 show 0000001 (dash); digit 2 shows 1111110 (0), or blank with SEG7_LEADING_ZERO_BLANK_EN defined.
- Set blink_en=1 with 0x123 loaded -> seg alternates between 2 scan ticks lit and 2 scan ticks 0000000 while dig_sel keeps scanning. Dropping blink_en -> seg is lit on the next cycle.
- Assert rst while dig_sel=100 with 0x456 loaded -> next cycle seg=0000000 and dig_sel=000; after release, digit 0 shows 1111110 (shadow cleared).
- ACTIVE_LOW=1 with load 0x008 -> in reset seg=1111111 and dig_sel=111. Scanning digit 0: seg=0000000, dig_sel=110.
